// File: rtl/fifo_rd_scheduler.sv
// Round-robin burst scheduler: drains standard-mode source FIFOs into one sink
// FIFO write port, one grant at a time, with a fixed 2-cycle rden->wren latency.
module fifo_rd_scheduler #(
    parameter  int N_SRC     = 4,
    parameter  int IF_WIDTH  = 256,
    parameter  int BURST_LEN = 16,
    localparam int ID_W      = (N_SRC > 2) ? $clog2(N_SRC) : 1,
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [N_SRC*IF_WIDTH-1:0] src_rddata,
    output logic [N_SRC-1:0]          src_rden,
    input  logic [N_SRC-1:0]          src_empty,
    output logic [IF_WIDTH-1:0]       snk_wrdata,
    output logic                      snk_wren,
    input  logic                      snk_full,
    input  logic                      snk_almostfull,
    output logic [ID_W-1:0]           cur_src,
    output logic                      busy
);
    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]   r_last, r_cur, r_sel_q, w_win;
    logic              w_win_vld, w_grant, w_exit, w_rd, w_bp, r_rd_q;
    logic [IF_WIDTH-1:0] w_src_arr [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign w_src_arr[g] = src_rddata[IF_WIDTH*g +: IF_WIDTH];
    end

    assign w_bp = snk_almostfull | snk_full;

    // Rotating priority: first requester after the last granted index, with wrap.
    always_comb begin
        int j;
        logic [ID_W-1:0] idx;
        w_win     = '0;
        w_win_vld = 1'b0;
        j         = 0;
        idx       = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            j = int'(r_last) + k;
            if (j >= N_SRC) j = j - N_SRC;
            idx = ID_W'(j);
            if (!w_win_vld && !src_empty[idx]) begin
                w_win_vld = 1'b1;
                w_win     = idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_exit      = 1'b0;
        w_rd        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_win_vld && !w_bp) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_rd = enable && !src_empty[r_cur] && !w_bp && (r_cnt < CNT_W'(BURST_LEN));
                // Leave on the edge of the final read so the next cycle is already IDLE.
                if (!enable || src_empty[r_cur] || (r_cnt >= CNT_W'(BURST_LEN)) ||
                    (w_rd && (r_cnt == CNT_W'(BURST_LEN - 1)))) begin
                    w_exit      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        src_rden        = '0;
        src_rden[r_cur] = w_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= ID_W'(N_SRC - 1);
            r_cur   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_cur <= w_win;
                r_cnt <= '0;
            end else if (w_rd) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_exit) r_last <= r_cur;
        end
    end

    // Source data lands one cycle after rden; register it once more into the sink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_q     <= 1'b0;
            r_sel_q    <= '0;
            snk_wren   <= 1'b0;
            snk_wrdata <= '0;
        end else begin
            r_rd_q   <= |src_rden;
            r_sel_q  <= r_cur;
            snk_wren <= r_rd_q;
            if (r_rd_q) snk_wrdata <= w_src_arr[r_sel_q];
        end
    end

    assign cur_src = r_cur;
    assign busy    = (r_state == S_BURST) | r_rd_q | snk_wren;

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Directed bench for fifo_rd_scheduler: behavioural source FIFOs, sink logger,
// one task per scenario with hand-derived expectations.
module tb_fifo_rd_scheduler;
    localparam int NS = 4;
    localparam int W  = 32;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          snk_almostfull = 1'b0;
    logic          snk_full = 1'b0;
    logic [NS*W-1:0] src_rddata;
    logic [NS-1:0] src_rden, src_empty;
    logic [W-1:0]  snk_wrdata;
    logic          snk_wren;
    logic [1:0]    cur_src;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    int load  [NS] = '{default: 0};
    int rdptr [NS];

    int          cyc = 0;
    int          rd_cyc [$];
    int          rd_src [$];
    int          wr_cyc [$];
    logic [W-1:0] wr_dat [$];

    fifo_rd_scheduler #(.N_SRC(NS), .IF_WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .src_rddata(src_rddata), .src_rden(src_rden), .src_empty(src_empty),
        .snk_wrdata(snk_wrdata), .snk_wren(snk_wren),
        .snk_full(snk_full), .snk_almostfull(snk_almostfull),
        .cur_src(cur_src), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] wd(input int s, input int n);
        return {s[7:0], n[23:0]};
    endfunction

    // Standard-mode source FIFOs: word n of source s is wd(s,n), valid after rden.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) rdptr[i] <= 0;
            src_rddata <= '0;
        end else begin
            for (int i = 0; i < NS; i++)
                if (src_rden[i]) begin
                    src_rddata[W*i +: W] <= wd(i, rdptr[i]);
                    rdptr[i] <= rdptr[i] + 1;
                end
        end
    end

    always_comb begin
        src_empty = '0;
        for (int i = 0; i < NS; i++) src_empty[i] = (rdptr[i] >= load[i]);
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NS; i++)
            if (src_rden[i]) begin
                rd_cyc.push_back(cyc);
                rd_src.push_back(i);
            end
        if (snk_wren) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(snk_wrdata);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; enable = 1'b0; snk_almostfull = 1'b0; snk_full = 1'b0;
        for (int i = 0; i < NS; i++) load[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (wr_dat.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_reads(input int n, output bit ok);
        int seen;
        seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (src_rden != '0) seen++;
            if (seen == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (src_rden !== 4'b0) begin n_bad++; $display("FAIL reset_rden: got %b want 0000", src_rden); end
        n_cmp++; if (snk_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %b want 0", snk_wren); end
        n_cmp++; if (snk_wrdata !== '0) begin n_bad++; $display("FAIL reset_wrdata: got %h want 0", snk_wrdata); end
        n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL reset_cur_src: got %0d want 0", cur_src); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int rb, wb, bad;
        bit ok;
        int len [$];
        int gap [$];
        do_reset();
        rb = rd_cyc.size(); wb = wr_dat.size();
        load[0] = 40; enable = 1'b1;
        wait_wr(wb + 40, 300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d writes want 40", wr_dat.size() - wb); end
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (rd_cyc.size() - rb != 40) begin n_bad++; $display("FAIL single_reads: got %0d want 40", rd_cyc.size() - rb); end
        bad = 0;
        for (int k = 0; k < 40 && wb + k < wr_dat.size(); k++)
            if (wr_dat[wb+k] !== wd(0, k)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_data: got %0d bad words want 0", bad); end
        if (rd_cyc.size() > rb) begin
            len.push_back(1);
            for (int k = rb + 1; k < rd_cyc.size(); k++)
                if (rd_cyc[k] - rd_cyc[k-1] == 1) len[len.size()-1]++;
                else begin gap.push_back(rd_cyc[k] - rd_cyc[k-1]); len.push_back(1); end
        end
        n_cmp++;
        if (len.size() != 3 || len[0] != 16 || len[1] != 16 || len[2] != 8) begin
            n_bad++; $display("FAIL single_bursts: got %0d bursts (first len %0d) want 16,16,8", len.size(), (len.size() > 0) ? len[0] : 0);
        end
        bad = 0;
        foreach (gap[i]) if (gap[i] != 2) bad++;
        n_cmp++; if (bad != 0 || gap.size() != 2) begin n_bad++; $display("FAIL single_gap: got %0d gaps with %0d wrong want 2 gaps of 2 cycles", gap.size(), bad); end
        if (rd_cyc.size() > rb && wr_cyc.size() > wb) begin
            n_cmp++;
            if (wr_cyc[wb] - rd_cyc[rb] != 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", wr_cyc[wb] - rd_cyc[rb]); end
        end
    endtask

    task automatic test_fairness();
        int rb, wb, bad, s, n;
        bit ok;
        do_reset();
        rb = rd_cyc.size(); wb = wr_dat.size();
        for (int i = 0; i < NS; i++) load[i] = 32;
        enable = 1'b1;
        wait_wr(wb + 128, 800, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fair_timeout: got %0d writes want 128", wr_dat.size() - wb); end
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (rd_cyc.size() - rb != 128) begin n_bad++; $display("FAIL fair_reads: got %0d want 128", rd_cyc.size() - rb); end
        for (int g = 0; g < 8; g++) begin
            bad = 0;
            for (int j = 0; j < 16; j++)
                if (rb + 16*g + j >= rd_src.size() || rd_src[rb + 16*g + j] != g % 4) bad++;
            n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL fair_group%0d: got %0d reads off-source want all from %0d", g, bad, g % 4); end
        end
        bad = 0;
        for (int k = 0; k < 128 && wb + k < wr_dat.size(); k++) begin
            s = (k / 16) % 4;
            n = (k / 64) * 16 + k % 16;
            if (wr_dat[wb+k] !== wd(s, n)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL fair_data: got %0d bad words want 0", bad); end
    endtask

    task automatic test_backpressure();
        int rb, wb, bad;
        bit ok;
        do_reset();
        rb = rd_cyc.size(); wb = wr_dat.size();
        load[0] = 16; snk_full = 1'b1; enable = 1'b1;
        bad = 0;
        repeat (4) begin @(negedge clk); if (src_rden !== 4'b0 || busy !== 1'b0) bad++; end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_full_idle: got %0d cycles granted/reading want 0", bad); end
        @(posedge clk); #1 snk_full = 1'b0;
        wait_reads(7, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout7: got no 7th read want 7 reads"); end
        @(posedge clk); #1 snk_almostfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (src_rden !== 4'b0 || busy !== 1'b1 || cur_src !== 2'd0) begin
                n_bad++; $display("FAIL bp_stall%0d: got rden=%b busy=%b cur=%0d want 0000/1/0", c, src_rden, busy, cur_src);
            end
        end
        @(posedge clk); #1 snk_almostfull = 1'b0;
        wait_wr(wb + 16, 100, ok);
        repeat (6) @(posedge clk); #1;
        n_cmp++; if (rd_cyc.size() - rb != 16) begin n_bad++; $display("FAIL bp_reads: got %0d want 16", rd_cyc.size() - rb); end
        if (rd_cyc.size() - rb >= 8) begin
            n_cmp++;
            if (rd_cyc[rb+7] - rd_cyc[rb+6] != 6) begin n_bad++; $display("FAIL bp_gap: got %0d want 6", rd_cyc[rb+7] - rd_cyc[rb+6]); end
        end
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (wb + k >= wr_dat.size() || wr_dat[wb+k] !== wd(0, k)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_data: got %0d bad words want 0", bad); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_underflow();
        int rb, wb, bad, k;
        int exp_src [$];
        int ptr [NS];
        bit ok;
        do_reset();
        rb = rd_cyc.size(); wb = wr_dat.size();
        load[0] = 20; load[1] = 2; load[2] = 3; load[3] = 4;
        repeat (16) exp_src.push_back(0);
        repeat (2)  exp_src.push_back(1);
        repeat (3)  exp_src.push_back(2);
        repeat (4)  exp_src.push_back(3);
        repeat (4)  exp_src.push_back(0);
        enable = 1'b1;
        wait_wr(wb + 29, 400, ok);
        repeat (6) @(posedge clk); #1;
        n_cmp++; if (rd_cyc.size() - rb != 29) begin n_bad++; $display("FAIL uf_reads: got %0d want 29", rd_cyc.size() - rb); end
        bad = 0;
        foreach (exp_src[i]) if (rb + i >= rd_src.size() || rd_src[rb+i] != exp_src[i]) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL uf_order: got %0d reads off-order want 0", bad); end
        if (rd_src.size() > rb + 21) begin
            n_cmp++;
            if (rd_src[rb+21] != 3) begin n_bad++; $display("FAIL uf_next_after_2: got %0d want 3", rd_src[rb+21]); end
        end
        for (int i = 0; i < NS; i++) ptr[i] = 0;
        bad = 0;
        foreach (exp_src[i]) begin
            k = exp_src[i];
            if (wb + i >= wr_dat.size() || wr_dat[wb+i] !== wd(k, ptr[k])) bad++;
            ptr[k]++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL uf_data: got %0d bad words want 0", bad); end
    endtask

    task automatic test_enable_drop();
        int rb, wb, bad;
        bit ok;
        do_reset();
        rb = rd_cyc.size(); wb = wr_dat.size();
        load[0] = 16; enable = 1'b1;
        wait_reads(5, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL en_timeout5: got no 5th read want 5 reads"); end
        @(posedge clk); #1 enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (src_rden !== 4'b0) begin n_bad++; $display("FAIL en_rden_T: got %b want 0000", src_rden); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || snk_wren !== 1'b1) begin n_bad++; $display("FAIL en_busy_T1: got busy=%b wren=%b want 1/1", busy, snk_wren); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_busy_T2: got %b want 0", busy); end
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (rd_cyc.size() - rb != 5 || wr_dat.size() - wb != 5) begin
            n_bad++; $display("FAIL en_counts: got %0d reads %0d writes want 5/5", rd_cyc.size() - rb, wr_dat.size() - wb);
        end
        bad = 0;
        for (int k = 0; k < 5 && wb + k < wr_dat.size(); k++) if (wr_dat[wb+k] !== wd(0, k)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL en_data: got %0d bad words want 0", bad); end
    endtask

    task automatic test_reset_mid_burst();
        int wc;
        bit ok;
        do_reset();
        load[1] = 16; load[2] = 5; enable = 1'b1;
        wait_reads(6, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmb_timeout6: got no 6th read want 6 reads"); end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (src_rden !== 4'b0 || snk_wren !== 1'b0 || snk_wrdata !== '0 || cur_src !== 2'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rmb_async: got rden=%b wren=%b data=%h cur=%0d busy=%b want all 0", src_rden, snk_wren, snk_wrdata, cur_src, busy);
        end
        wc = wr_dat.size();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (wr_dat.size() != wc) begin n_bad++; $display("FAIL rmb_no_write: got %0d writes during reset want 0", wr_dat.size() - wc); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (src_rden != '0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || src_rden !== 4'b0010) begin n_bad++; $display("FAIL rmb_first_grant: got %b want 0010", src_rden); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_underflow();
        test_enable_drop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
